seg7_scan_display: RTL

//  Time-multiplexed 8-digit seven-segment driver downstream of the CPU top level.

---
 rtl/seg7_scan_display_pkg.sv | 27 ++
 rtl/seg7_scan_display_if.sv | 22 ++
 rtl/seg7_scan_display_hex_to_seg7.sv | 12 +
 rtl/seg7_scan_display.sv | 118 +++++++++++
 4 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Shared constants, types and segment table for the 8-digit scanned seven-segment driver.
package seg7_scan_display_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;

    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] EN_NONE   = 8'hFF;

    // Active-low a..g patterns (bit 6 = a, bit 0 = g), entry n is hex digit n.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    typedef logic [IDX_W-1:0] digit_idx_t;

    // Left group (digits 7..4) in a, right group (digits 3..0) in b.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } num_pair_t;

endpackage

// File: rtl/seg7_scan_display_if.sv
// Value/strobe inputs and scanned display outputs of the seven-segment driver.
interface seg7_scan_display_if;
    import seg7_scan_display_pkg::*;

    logic [DATA_W-1:0]     NumberA;
    logic [DATA_W-1:0]     NumberB;
    logic                  Update;
    logic [SEG_W-1:0]      out7;
    logic [NUM_DIGITS-1:0] en_out;
    logic                  FrameDone;

    modport master (
        output NumberA, NumberB, Update,
        input  out7, en_out, FrameDone
    );

    modport slave (
        input  NumberA, NumberB, Update,
        output out7, en_out, FrameDone
    );

endinterface

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
    import seg7_scan_display_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] segs_c
);

    // Table lookup from the shared segment map.
    assign segs_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 8-digit hex display: two 16-bit groups, frame-aligned updates,
// optional per-group leading-zero blanking.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 12500,
    parameter bit          BLANK_LZ    = 1'b1
)(
    input  logic                Clk,
    input  logic                Rst,
    seg7_scan_display_if.slave  bus
);

    localparam int unsigned       PRESC_W    = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

    logic [PRESC_W-1:0]    presc_q;
    digit_idx_t            idx_q;
    digit_idx_t            idx_next_c;
    num_pair_t             staging_q;
    num_pair_t             display_q;
    num_pair_t             display_next_c;
    num_pair_t             inputs_c;
    logic                  pending_q;
    logic                  tick_c;
    logic                  boundary_c;

    logic [DATA_W-1:0]     group_c;
    logic [1:0]            pos_c;
    logic [NIB_W-1:0]      nibble_c;
    logic                  lead_zero_c;
    logic                  blank_c;
    logic [SEG_W-1:0]      seg_c;

    logic [SEG_W-1:0]      out7_q;
    logic [NUM_DIGITS-1:0] en_q;
    logic                  frame_done_q;

    // Slot timing and the display contents that the next digit drive will see.
    always_comb begin
        inputs_c       = {bus.NumberA, bus.NumberB};
        tick_c         = (presc_q == PRESC_LAST);
        boundary_c     = tick_c && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
        idx_next_c     = idx_q + digit_idx_t'(1);
        display_next_c = display_q;
        if (boundary_c && bus.Update) begin
            display_next_c = inputs_c;
        end else if (boundary_c && pending_q) begin
            display_next_c = staging_q;
        end
    end

    // Pick the nibble for the upcoming digit and decide whether it is a leading zero.
    always_comb begin
        group_c     = idx_next_c[2] ? display_next_c.a : display_next_c.b;
        pos_c       = idx_next_c[1:0];
        nibble_c    = group_c[{pos_c, 2'b00} +: NIB_W];
        lead_zero_c = ((group_c >> {pos_c, 2'b00}) == '0);
        blank_c     = BLANK_LZ && (pos_c != 2'd0) && lead_zero_c;
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_c),
        .segs_c (seg_c)
    );

    // Prescaler and digit index; a slot ends when the prescaler reaches its last count.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (tick_c) begin
            presc_q <= '0;
            idx_q   <= idx_next_c;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    // Staging capture, pending flag and frame-aligned display load.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            staging_q <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
        end else begin
            if (bus.Update) begin
                staging_q <= inputs_c;
            end
            if (boundary_c && (bus.Update || pending_q)) begin
                pending_q <= 1'b0;
            end else if (bus.Update) begin
                pending_q <= 1'b1;
            end
            display_q <= display_next_c;
        end
    end

    // Registered digit drive, refreshed on each slot tick; FrameDone is a one-cycle pulse.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out7_q       <= SEG_BLANK;
            en_q         <= EN_NONE;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= boundary_c;
            if (tick_c) begin
                out7_q <= blank_c ? SEG_BLANK : seg_c;
                en_q   <= blank_c ? EN_NONE : ~(NUM_DIGITS'(1) << idx_next_c);
            end
        end
    end

    assign bus.out7      = out7_q;
    assign bus.en_out    = en_q;
    assign bus.FrameDone = frame_done_q;

endmodule
